chan_scan_mux: RTL and testbench

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

---
 rtl/chan_scan_pkg.sv | 13 +
 rtl/next_chan_find.sv | 39 +++
 rtl/chan_scan_mux.sv | 116 +++++++++++
 tb/tb_chan_scan_mux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/chan_scan_pkg.sv
// Shared state encoding and mode constants for the channel scan multiplexer.
package chan_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/next_chan_find.sv
// Next-channel search: lowest set mask bit strictly above ptr, else lowest set bit overall.
// Latency: combinational, no clock.
// Backpressure: none; pure function of mask and ptr.
module next_chan_find #(
    parameter  int NCH = 8,
    localparam int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] mask,
    input  logic [SW-1:0]  ptr,
    output logic [SW-1:0]  nxt,
    output logic           wrapped,
    output logic           none
);

    logic [SW-1:0] lo_idx;
    logic [SW-1:0] hi_idx;
    logic          hi_hit;

    // Descending walk: the last hit written is the lowest qualifying index.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_hit = 1'b0;
        none   = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lo_idx = SW'(i);
                none   = 1'b0;
                if (i > int'(ptr)) begin
                    hi_idx = SW'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        nxt     = hi_hit ? hi_idx : lo_idx;
        wrapped = !hi_hit && !none;
    end

endmodule

// File: rtl/chan_scan_mux.sv
// Channel multiplexer with manual select and masked round-robin auto-scan with per-channel dwell.
// Latency: one clock from sel/din to dout.
// Backpressure: dout_vld & !dout_rdy freezes outputs, pointer, dwell counter and state.
module chan_scan_mux
    import chan_scan_pkg::*;
#(
    parameter  int NCH     = 8,
    parameter  int W       = 1,
    parameter  int DWELL_W = 4,
    localparam int SW      = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*W-1:0]   din,
    input  logic [SW-1:0]      sel,
    input  logic               mode,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH-1:0]     ch_mask,
    output logic [W-1:0]       dout,
    output logic [SW-1:0]      dout_ch,
    output logic               dout_vld,
    input  logic               dout_rdy,
    output logic               wrap
);

    state_t             state;
    state_t             ns;
    logic [SW-1:0]      ptr;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;

    logic               free;
    logic               entry;
    logic               adv;
    logic               man_ok;
    logic [SW-1:0]      find_ptr;
    logic [SW-1:0]      nxt_idx;
    logic               nxt_wrap;
    logic               mask_none;
    logic [SW-1:0]      tgt;

    assign free   = !dout_vld || dout_rdy;
    assign entry  = (state != SCAN);
    assign adv    = (cnt == dwell_q) || !ch_mask[ptr];
    assign man_ok = int'(sel) < NCH;

    // Searching from the top index yields the lowest set bit, which is the scan entry point.
    assign find_ptr = entry ? SW'(NCH - 1) : ptr;
    assign tgt      = (entry || adv) ? nxt_idx : ptr;

    next_chan_find #(
        .NCH (NCH)
    ) u_next_chan_find (
        .mask    (ch_mask),
        .ptr     (find_ptr),
        .nxt     (nxt_idx),
        .wrapped (nxt_wrap),
        .none    (mask_none)
    );

    always_comb begin
        ns = IDLE;
        if (!en || (mode == MODE_SCAN && mask_none)) begin
            ns = IDLE;
        end else if (mode == MODE_MAN) begin
            ns = MAN;
        end else begin
            ns = SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            dwell_q  <= '0;
            dout     <= '0;
            dout_ch  <= '0;
            dout_vld <= 1'b0;
            wrap     <= 1'b0;
        end else if (free) begin
            state <= ns;
            case (ns)
                MAN: begin
                    wrap     <= 1'b0;
                    dout_vld <= man_ok;
                    if (man_ok) begin
                        dout    <= din[int'(sel)*W +: W];
                        dout_ch <= sel;
                    end
                end
                SCAN: begin
                    dout_vld <= 1'b1;
                    dout     <= din[int'(tgt)*W +: W];
                    dout_ch  <= tgt;
                    ptr      <= tgt;
                    if (entry || adv) begin
                        cnt     <= '0;
                        dwell_q <= dwell;
                        wrap    <= !entry && nxt_wrap;
                    end else begin
                        cnt  <= cnt + DWELL_W'(1);
                        wrap <= 1'b0;
                    end
                end
                default: begin
                    dout_vld <= 1'b0;
                    wrap     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux at NCH=8, W=1, DWELL_W=4.
module tb_chan_scan_mux;

    localparam int NCH     = 8;
    localparam int W       = 1;
    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NCH*W-1:0]   din;
    logic [2:0]         sel;
    logic               mode;
    logic               en;
    logic [DWELL_W-1:0] dwell;
    logic [NCH-1:0]     ch_mask;
    logic [W-1:0]       dout;
    logic [2:0]         dout_ch;
    logic               dout_vld;
    logic               dout_rdy;
    logic               wrap;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_v;

    int man_d [8]  = '{0, 1, 1, 0, 1, 1, 0, 1};
    int sa_ch [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int sa_d  [10] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1};
    int sa_w  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int sd_ch [10] = '{2, 2, 2, 5, 5, 5, 2, 2, 2, 5};
    int sd_d  [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    int sd_w  [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int st_ch [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
    int st_d  [13] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int mz_w  [5]  = '{0, 0, 0, 0, 1};
    int ar_ch [4]  = '{3, 6, 7, 3};
    int ar_d  [4]  = '{1, 0, 0, 1};
    int ar_w  [4]  = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    chan_scan_mux #(
        .NCH     (NCH),
        .W       (W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .sel      (sel),
        .mode     (mode),
        .en       (en),
        .dwell    (dwell),
        .ch_mask  (ch_mask),
        .dout     (dout),
        .dout_ch  (dout_ch),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .wrap     (wrap)
    );

    task automatic test_reset();
        rst_n = 1'b0; din = 8'hFF; sel = 3'd3; mode = 1'b0; en = 1'b1;
        dwell = '0; ch_mask = 8'hFF; dout_rdy = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({dout_vld, dout_ch, dout, wrap} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: got vld/ch/d/wrap=%b/%0d/%b/%b want all 0", dout_vld, dout_ch, dout, wrap);
        end
        en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got vld=%b want 0", dout_vld);
        end
    endtask

    task automatic test_manual();
        din = 8'b10110110; en = 1'b1; mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            @(negedge clk);
            exp_v = {1'b1, 3'(k), 1'(man_d[k]), 1'b0};
            checks++;
            if ({dout_vld, dout_ch, dout, wrap} !== exp_v) begin
                errors++;
                $display("FAIL manual sel=%0d: got vld/ch/d/wrap=%b/%0d/%b/%b want %b", k, dout_vld, dout_ch, dout, wrap, exp_v);
            end
        end
    endtask

    task automatic test_scan_all();
        mode = 1'b1; ch_mask = 8'hFF; dwell = 4'd0; din = 8'b01011010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_v = {1'b1, 3'(sa_ch[i]), 1'(sa_d[i]), 1'(sa_w[i])};
            checks++;
            if ({dout_vld, dout_ch, dout, wrap} !== exp_v) begin
                errors++;
                $display("FAIL scan_all beat %0d: got vld/ch/d/wrap=%b/%0d/%b/%b want %b", i, dout_vld, dout_ch, dout, wrap, exp_v);
            end
        end
    endtask

    task automatic test_scan_dwell();
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout_vld, dout_ch} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL idle_retain: got vld=%b ch=%0d want vld=0 ch=1", dout_vld, dout_ch);
        end
        en = 1'b1; ch_mask = 8'b00100100; dwell = 4'd2; din = 8'b00100000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_v = {1'b1, 3'(sd_ch[i]), 1'(sd_d[i]), 1'(sd_w[i])};
            checks++;
            if ({dout_vld, dout_ch, dout, wrap} !== exp_v) begin
                errors++;
                $display("FAIL scan_dwell beat %0d: got vld/ch/d/wrap=%b/%0d/%b/%b want %b", i, dout_vld, dout_ch, dout, wrap, exp_v);
            end
        end
    endtask

    task automatic test_stall();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1; ch_mask = 8'hFF; dwell = 4'd3; din = 8'hA5;
        for (int i = 0; i < 13; i++) begin
            if (i == 6) begin
                dout_rdy = 1'b0;
                din = ~din;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checks++;
                    if ({dout_vld, dout_ch, dout, wrap} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
                        errors++;
                        $display("FAIL stall cycle %0d: got vld/ch/d/wrap=%b/%0d/%b/%b want 1/1/0/0", s, dout_vld, dout_ch, dout, wrap);
                    end
                    din = ~din;
                end
                dout_rdy = 1'b1;
                din = 8'hA5;
            end
            @(negedge clk);
            exp_v = {1'b1, 3'(st_ch[i]), 1'(st_d[i]), 1'b0};
            checks++;
            if ({dout_vld, dout_ch, dout, wrap} !== exp_v) begin
                errors++;
                $display("FAIL stall_seq beat %0d: got vld/ch/d/wrap=%b/%0d/%b/%b want %b", i, dout_vld, dout_ch, dout, wrap, exp_v);
            end
        end
    endtask

    task automatic test_mask_zero();
        ch_mask = 8'h00; dout_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout_vld, dout_ch} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL mask_zero_pending: got vld=%b ch=%0d want vld=1 ch=3", dout_vld, dout_ch);
        end
        dout_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({dout_vld, dout_ch} !== {1'b0, 3'd3}) begin
            errors++;
            $display("FAIL mask_zero_idle: got vld=%b ch=%0d want vld=0 ch=3", dout_vld, dout_ch);
        end
        ch_mask = 8'h10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_v = {1'b1, 3'd4, 1'b0, 1'(mz_w[i])};
            checks++;
            if ({dout_vld, dout_ch, dout, wrap} !== exp_v) begin
                errors++;
                $display("FAIL mask_restore beat %0d: got vld/ch/d/wrap=%b/%0d/%b/%b want %b", i, dout_vld, dout_ch, dout, wrap, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1; mode = 1'b1; ch_mask = 8'hFF; dwell = 4'd0; din = 8'b00101000;
        repeat (6) @(negedge clk);
        checks++;
        if ({dout_vld, dout_ch, dout} !== {1'b1, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_ptr: got vld=%b ch=%0d d=%b want 1/5/1", dout_vld, dout_ch, dout);
        end
        #2;
        rst_n = 1'b0;
        ch_mask = 8'b11001000;
        #1;
        checks++;
        if ({dout_vld, dout_ch, dout, wrap} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got vld/ch/d/wrap=%b/%0d/%b/%b want all 0", dout_vld, dout_ch, dout, wrap);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_v = {1'b1, 3'(ar_ch[i]), 1'(ar_d[i]), 1'(ar_w[i])};
            checks++;
            if ({dout_vld, dout_ch, dout, wrap} !== exp_v) begin
                errors++;
                $display("FAIL post_reset beat %0d: got vld/ch/d/wrap=%b/%0d/%b/%b want %b", i, dout_vld, dout_ch, dout, wrap, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan_all();
        test_scan_dwell();
        test_stall();
        test_mask_zero();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
